// File: rtl/sdram_cmd_fifo_arbiter.sv
// sdram_cmd_fifo_arbiter
//   Write-side scheduler for the shared async command/data FIFO that feeds the SDRAM clock
//   domain. Two wr_clk-domain requesters (req0 = AXI write path, req1 = AXI read path) each
//   submit whole bursts. Bursts are granted atomically. Every pushed word is tagged with its
//   source ID in the MSB, and pushes are throttled by fifo_full_i.
//
//   Configuration macro: ARB_FIXED_PRIO_EN
//     undefined (default): round-robin tie break, req0 wins the first tie after reset
//     defined            : req0 always wins a tie (req1 may starve)
//
// Ports
//   wr_clk          FIFO write-domain clock, all logic on posedge
//   reset_n         asynchronous active-low reset (shared with the FIFO)
//   reqN_valid_i    requester N beat valid
//   reqN_ready_o    requester N beat accepted (valid & ready = push)
//   reqN_len_i      requester N burst length-1, sampled only at grant
//   reqN_data_i     requester N beat payload
//   fifo_full_i     async FIFO full flag (write domain)
//   fifo_wr_en_o    push strobe to the async FIFO
//   fifo_data_in_o  {source_id, payload} pushed to the async FIFO
//   grant_id_o      requester currently / last granted
//   busy_o          high while a burst is in progress
//   burst_done_o    one-cycle pulse in the cycle after the final beat is pushed

module sdram_cmd_fifo_arbiter #(
    parameter int unsigned DW   = 32,
    parameter int unsigned LENW = 4
) (
    input  logic            wr_clk,
    input  logic            reset_n,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [LENW-1:0] req0_len_i,
    input  logic [DW-1:0]   req0_data_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [LENW-1:0] req1_len_i,
    input  logic [DW-1:0]   req1_data_i,
    input  logic            fifo_full_i,
    output logic            fifo_wr_en_o,
    output logic [DW:0]     fifo_data_in_o,
    output logic            grant_id_o,
    output logic            busy_o,
    output logic            burst_done_o
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e          state_q, state_d;
    logic [LENW-1:0] beat_cnt_q, beat_cnt_d;
    logic            grant_q, grant_d;
    logic            done_q, done_d;
    logic            winner;
    logic            granted_valid;
    logic            push;

`ifndef ARB_FIXED_PRIO_EN
    logic            rr_last_q, rr_last_d;
`endif

    // Tie break: round robin favours the requester not served last.
    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        winner = req0_valid_i ? 1'b0 : 1'b1;
`else
        if (req0_valid_i && req1_valid_i) begin
            winner = ~rr_last_q;
        end else begin
            winner = req1_valid_i;
        end
`endif
    end

    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        grant_d        = grant_q;
        done_d         = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        rr_last_d      = rr_last_q;
`endif
        req0_ready_o   = 1'b0;
        req1_ready_o   = 1'b0;
        fifo_wr_en_o   = 1'b0;
        fifo_data_in_o = '0;
        granted_valid  = 1'b0;
        push           = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Arbitration bubble: nothing is pushed in this state.
                if (req0_valid_i || req1_valid_i) begin
                    grant_d    = winner;
                    beat_cnt_d = winner ? req1_len_i : req0_len_i;
                    state_d    = StBurst;
                end
            end
            StBurst: begin
                req0_ready_o  = ~grant_q & ~fifo_full_i;
                req1_ready_o  = grant_q & ~fifo_full_i;
                granted_valid = grant_q ? req1_valid_i : req0_valid_i;
                push          = granted_valid & ~fifo_full_i;
                if (push) begin
                    fifo_wr_en_o   = 1'b1;
                    fifo_data_in_o = {grant_q, (grant_q ? req1_data_i : req0_data_i)};
                    if (beat_cnt_q != '0) begin
                        beat_cnt_d = beat_cnt_q - LENW'(1);
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
                        rr_last_d = grant_q;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            grant_q    <= 1'b0;
            done_q     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_last_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
`ifndef ARB_FIXED_PRIO_EN
            rr_last_q  <= rr_last_d;
`endif
        end
    end

    assign grant_id_o   = grant_q;
    assign busy_o       = (state_q == StBurst);
    assign burst_done_o = done_q;

endmodule

// File: tb/tb_sdram_cmd_fifo_arbiter.sv
// Self-checking bench for sdram_cmd_fifo_arbiter: a cycle table from reset, directed
// stall / reset sequences, and randomized traffic against a burst-level reference model.

module tb_sdram_cmd_fifo_arbiter;

    localparam int DW   = 32;
    localparam int LENW = 4;
    localparam int VW   = DW + 7;

    logic            wr_clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic            req0_ready_o, req1_ready_o;
    logic [LENW-1:0] req0_len_i = '0, req1_len_i = '0;
    logic [DW-1:0]   req0_data_i = '0, req1_data_i = '0;
    logic            fifo_full_i = 1'b0;
    logic            fifo_wr_en_o;
    logic [DW:0]     fifo_data_in_o;
    logic            grant_id_o, busy_o, burst_done_o;

    sdram_cmd_fifo_arbiter #(.DW(DW), .LENW(LENW)) dut (
        .wr_clk        (wr_clk),
        .reset_n       (reset_n),
        .req0_valid_i  (req0_valid_i),
        .req0_ready_o  (req0_ready_o),
        .req0_len_i    (req0_len_i),
        .req0_data_i   (req0_data_i),
        .req1_valid_i  (req1_valid_i),
        .req1_ready_o  (req1_ready_o),
        .req1_len_i    (req1_len_i),
        .req1_data_i   (req1_data_i),
        .fifo_full_i   (fifo_full_i),
        .fifo_wr_en_o  (fifo_wr_en_o),
        .fifo_data_in_o(fifo_data_in_o),
        .grant_id_o    (grant_id_o),
        .busy_o        (busy_o),
        .burst_done_o  (burst_done_o)
    );

    always #5 wr_clk = ~wr_clk;

    int checks = 0;
    int failures = 0;

    // Reference model: burst in progress, its owner, beats still to push, next tie winner.
    bit m_busy, m_owner, m_tie, m_done;
    int m_left;

    logic [DW:0] push_log[$];

    typedef struct {
        logic            v0, v1;
        logic [LENW-1:0] l0, l1;
        logic [DW-1:0]   d0, d1;
        logic            full;
        logic [VW-1:0]   exp;
    } vec_t;

    vec_t tbl[13];

    // Output vector layout: {ready0, ready1, wr_en, data_in, grant, busy, done}
    function automatic logic [VW-1:0] dut_vec();
        return {req0_ready_o, req1_ready_o, fifo_wr_en_o, fifo_data_in_o,
                grant_id_o, busy_o, burst_done_o};
    endfunction

    function automatic bit model_push();
        return m_busy && !fifo_full_i && (m_owner ? req1_valid_i : req0_valid_i);
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [DW:0] d;
        d = model_push() ? {m_owner, (m_owner ? req1_data_i : req0_data_i)} : '0;
        return {m_busy && !m_owner && !fifo_full_i, m_busy && m_owner && !fifo_full_i,
                model_push(), d, m_owner, m_busy, m_done};
    endfunction

    function automatic vec_t mk(logic v0, logic v1, int l0, int l1, int d0, int d1,
                                logic full, logic r0, logic r1, logic wr, logic [DW:0] dat,
                                logic g, logic b, logic dn);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.l0 = LENW'(l0); v.l1 = LENW'(l1);
        v.d0 = DW'(d0); v.d1 = DW'(d1); v.full = full;
        v.exp = {r0, r1, wr, dat, g, b, dn};
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_tie = 0; m_done = 0; m_left = 0;
    endtask

    task automatic model_update();
        bit p;
        p = model_push();
        m_done = 0;
        if (!m_busy) begin
            if (req0_valid_i || req1_valid_i) begin
                m_owner = (req0_valid_i && req1_valid_i) ? m_tie : req1_valid_i;
                m_left  = int'(m_owner ? req1_len_i : req0_len_i) + 1;
                m_busy  = 1;
            end
        end else if (p) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
`ifndef ARB_FIXED_PRIO_EN
                m_tie = !m_owner;
`endif
            end
        end
    endtask

    task automatic check(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic v0, logic v1, logic [LENW-1:0] l0, logic [LENW-1:0] l1,
                         logic [DW-1:0] d0, logic [DW-1:0] d1, logic full);
        req0_valid_i = v0; req1_valid_i = v1; req0_len_i = l0; req1_len_i = l1;
        req0_data_i = d0; req1_data_i = d1; fifo_full_i = full;
    endtask

    // One cycle: drive at negedge, compare against model, log pushes, advance model at posedge.
    task automatic step(string name, logic v0, logic v1, logic [LENW-1:0] l0,
                        logic [LENW-1:0] l1, logic [DW-1:0] d0, logic [DW-1:0] d1, logic full);
        @(negedge wr_clk);
        drive(v0, v1, l0, l1, d0, d1, full);
        #1;
        check(name, dut_vec(), model_vec());
        if (fifo_wr_en_o) push_log.push_back(fifo_data_in_o);
        @(posedge wr_clk);
        model_update();
    endtask

    task automatic do_reset(logic v0, logic v1);
        @(negedge wr_clk);
        reset_n = 1'b0;
        drive(v0, v1, '0, '0, '0, '0, 1'b0);
        repeat (2) @(negedge wr_clk);
        #1;
        check("reset_outputs", dut_vec(), '0);
        @(negedge wr_clk);
        reset_n = 1'b1;
        model_reset();
        #1;
        check("release", dut_vec(), model_vec());
        @(posedge wr_clk);
        model_update();
    endtask

    function automatic int count_id(bit id);
        int n = 0;
        foreach (push_log[i]) if (push_log[i][DW] == id) n++;
        return n;
    endfunction

    initial begin
        int stall;
        int drop;
        logic [DW:0] w;

        // T1: reset held with both requesters valid, req0 wins the first tie.
        do_reset(1'b1, 1'b1);
        step("t1_grant0", 1, 1, 0, 0, 32'h11, 32'h22, 0);
        check_int("t1_first_grant", int'(grant_id_o), 0);

        // Cycle table from reset: single burst, full stall, ties.
        tbl[0]  = mk(1, 0, 3, 0, 'hA0, 0, 0,  0, 0, 0, '0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 3, 0, 'hA0, 0, 0,  1, 0, 1, 33'h0_000000A0, 0, 1, 0);
        tbl[2]  = mk(1, 0, 0, 0, 'hA1, 0, 0,  1, 0, 1, 33'h0_000000A1, 0, 1, 0);
        tbl[3]  = mk(1, 0, 0, 0, 'hA2, 0, 0,  1, 0, 1, 33'h0_000000A2, 0, 1, 0);
        tbl[4]  = mk(1, 0, 0, 0, 'hA3, 0, 0,  1, 0, 1, 33'h0_000000A3, 0, 1, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 'hB0, 0,  0, 0, 0, '0, 0, 0, 1);
        tbl[6]  = mk(0, 1, 0, 0, 0, 'hB0, 1,  0, 0, 0, '0, 1, 1, 0);
        tbl[7]  = mk(0, 1, 0, 0, 0, 'hB0, 0,  0, 1, 1, 33'h1_000000B0, 1, 1, 0);
        tbl[8]  = mk(1, 1, 0, 0, 'hC0, 'hD0, 0,  0, 0, 0, '0, 1, 0, 1);
        tbl[9]  = mk(1, 1, 0, 0, 'hC0, 'hD0, 0,  1, 0, 1, 33'h0_000000C0, 0, 1, 0);
        tbl[10] = mk(1, 1, 0, 0, 'hC1, 'hD1, 0,  0, 0, 0, '0, 0, 0, 1);
`ifdef ARB_FIXED_PRIO_EN
        tbl[11] = mk(1, 1, 0, 0, 'hC1, 'hD1, 0,  1, 0, 1, 33'h0_000000C1, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, '0, 0, 0, 1);
`else
        tbl[11] = mk(1, 1, 0, 0, 'hC1, 'hD1, 0,  0, 1, 1, 33'h1_000000D1, 1, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, '0, 1, 0, 1);
`endif
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            @(negedge wr_clk);
            drive(tbl[i].v0, tbl[i].v1, tbl[i].l0, tbl[i].l1, tbl[i].d0, tbl[i].d1,
                  tbl[i].full);
            #1;
            check($sformatf("tbl_row%0d", i), dut_vec(), tbl[i].exp);
        end

        // T4: fifo_full for 5 cycles after the 2nd beat of a 4-beat burst.
        do_reset(1'b0, 1'b0);
        push_log.delete();
        stall = 0;
        for (int c = 0; c < 20; c++) begin
            logic f;
            f = (push_log.size() == 2) && (stall < 5);
            if (f) stall++;
            step("t4_cycle", push_log.size() < 4, 0, 3, 0, DW'(32'hA0 + push_log.size()),
                 0, f);
        end
        check_int("t4_push_count", push_log.size(), 4);
        check_int("t4_stall_cycles", stall, 5);
        for (int i = 0; i < 4; i++) begin
            w = (i < push_log.size()) ? push_log[i] : '1;
            check_int($sformatf("t4_beat%0d", i), int'(w), 'hA0 + i);
        end

        // T5: granted req1 drops valid mid-burst while req0 waits.
        do_reset(1'b0, 1'b0);
        push_log.delete();
        drop = 0;
        step("t5_arb", 0, 1, 0, 3, 0, 32'hB0, 0);
        for (int c = 0; c < 30; c++) begin
            int n1;
            logic v1;
            n1 = count_id(1);
            v1 = (n1 < 4) && !(n1 == 1 && drop < 3);
            if (n1 == 1 && drop < 3) drop++;
            step("t5_cycle", count_id(0) < 1, v1, 0, 3, 32'hC0, DW'(32'hB0 + n1), 0);
        end
        check_int("t5_push_count", push_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            w = (i < push_log.size()) ? push_log[i] : '1;
            check_int($sformatf("t5_order%0d", i), int'(w[DW]), (i < 4) ? 1 : 0);
        end

        // T6: reset mid-burst, then a fresh 8-beat burst from full length.
        do_reset(1'b0, 1'b0);
        push_log.delete();
        for (int c = 0; c < 3; c++) begin
            step("t6_pre", 1, 0, 7, 0, DW'(32'hE0 + push_log.size()), 0, 0);
        end
        check_int("t6_pre_pushes", push_log.size(), 2);
        @(negedge wr_clk);
        reset_n = 1'b0;
        #1;
        check("t6_reset_async", dut_vec(), '0);
        do_reset(1'b0, 1'b0);
        push_log.delete();
        for (int c = 0; c < 20; c++) begin
            step("t6_post", push_log.size() < 8, 0, (c == 0) ? 7 : 0, 0,
                 DW'(32'hF0 + push_log.size()), 0, 0);
        end
        check_int("t6_post_pushes", push_log.size(), 8);

        // Randomized traffic against the reference model.
        do_reset(1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            step("rand", $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 LENW'($urandom), LENW'($urandom), $urandom, $urandom,
                 $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
